vga_scan_gen: RTL and testbench

VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

---
 rtl/vga_scan_gen_pkg.sv | 35 +++
 rtl/vga_scan_gen_if.sv | 30 +++
 rtl/vga_scan_gen_scan_counter.sv | 48 ++++
 rtl/vga_scan_gen.sv | 114 +++++++++++
 tb/tb_vga_scan_gen.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_scan_gen_pkg.sv
// Shared 640x480@60 timing constants and helpers for the scan generator and color_mapper.
// Optional feature macro used by this block: VGA_FRAME_CNT_EN (adds a 16-bit frame counter).
package vga_pkg;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned FCNT_W   = 16;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Inclusive sync windows and exclusive blank limits, in counter units
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
  localparam int unsigned H_BLANK_AT   = H_ACTIVE;
  localparam int unsigned V_BLANK_AT   = V_ACTIVE;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [FCNT_W-1:0]  frame_cnt_t;

  function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_scan_gen_if.sv
// Scan-output bundle of vga_scan_gen; frame_cnt exists only with VGA_FRAME_CNT_EN.
interface vga_scan_gen_if;
  import vga_pkg::*;

  logic   pixel_clk;
  logic   hs;
  logic   vs;
  logic   blank;
  coord_t DrawX;
  coord_t DrawY;
  logic   frame_start;
`ifdef VGA_FRAME_CNT_EN
  frame_cnt_t frame_cnt;
`endif

  modport master (
    output pixel_clk, hs, vs, blank, DrawX, DrawY, frame_start
`ifdef VGA_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    input pixel_clk, hs, vs, blank, DrawX, DrawY, frame_start
`ifdef VGA_FRAME_CNT_EN
    , input frame_cnt
`endif
  );

endinterface

// File: rtl/vga_scan_gen_scan_counter.sv
// Modulo-N counter with enable; exposes its next value so downstream flags can be registered in step.
module scan_counter #(
  parameter int unsigned N = 800,
  parameter int unsigned W = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_nxt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_last_s;

  // Next count: terminal-count compare only, so the value never leaves 0..N-1
  always_comb begin
    at_last_s = (cnt_q == LAST);
    if (en_i) begin
      if (at_last_s) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;
  assign wrap_o    = en_i & at_last_s;

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster scan generator: half-rate pixel strobe, X/Y counters, registered sync/blank/frame_start.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int unsigned HACT  = H_ACTIVE,
  parameter int unsigned HFP   = H_FP,
  parameter int unsigned HSYNC = H_SYNC,
  parameter int unsigned HBP   = H_BP,
  parameter int unsigned VACT  = V_ACTIVE,
  parameter int unsigned VFP   = V_FP,
  parameter int unsigned VSYNC = V_SYNC,
  parameter int unsigned VBP   = V_BP
) (
  input  logic           Clk,
  input  logic           Reset,
  vga_scan_gen_if.master vga_o
);

  localparam int unsigned HTOT = HACT + HFP + HSYNC + HBP;
  localparam int unsigned VTOT = VACT + VFP + VSYNC + VBP;

  localparam coord_t HS_START = coord_t'(HACT + HFP);
  localparam coord_t HS_END   = coord_t'(HACT + HFP + HSYNC - 1);
  localparam coord_t VS_START = coord_t'(VACT + VFP);
  localparam coord_t VS_END   = coord_t'(VACT + VFP + VSYNC - 1);
  localparam coord_t H_VIS    = coord_t'(HACT);
  localparam coord_t V_VIS    = coord_t'(VACT);

  logic   pclk_q, pclk_d;
  logic   hs_q, hs_d;
  logic   vs_q, vs_d;
  logic   blank_q, blank_d;
  logic   fs_q, fs_d;
  coord_t x_cnt_s, x_nxt_s, y_cnt_s, y_nxt_s;
  logic   x_wrap_s, y_wrap_s;

  scan_counter #(.N(HTOT), .W(COORD_W)) u_x_cnt (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .en_i      (pclk_q),
    .cnt_o     (x_cnt_s),
    .cnt_nxt_o (x_nxt_s),
    .wrap_o    (x_wrap_s)
  );

  scan_counter #(.N(VTOT), .W(COORD_W)) u_y_cnt (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .en_i      (x_wrap_s),
    .cnt_o     (y_cnt_s),
    .cnt_nxt_o (y_nxt_s),
    .wrap_o    (y_wrap_s)
  );

  // Flags derive from next-count values so they register alongside the counters they describe
  always_comb begin
    pclk_d  = ~pclk_q;
    hs_d    = ~in_range(x_nxt_s, HS_START, HS_END);
    vs_d    = ~in_range(y_nxt_s, VS_START, VS_END);
    blank_d = (x_nxt_s < H_VIS) && (y_nxt_s < V_VIS);
    fs_d    = y_wrap_s;
  end

  // Output registers; reset leaves frame_start low so the reset (0,0) is not a frame start
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pclk_q  <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      pclk_q  <= pclk_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
    end
  end

  assign vga_o.pixel_clk   = pclk_q;
  assign vga_o.hs          = hs_q;
  assign vga_o.vs          = vs_q;
  assign vga_o.blank       = blank_q;
  assign vga_o.DrawX       = x_cnt_s;
  assign vga_o.DrawY       = y_cnt_s;
  assign vga_o.frame_start = fs_q;

`ifdef VGA_FRAME_CNT_EN
  frame_cnt_t frame_cnt_q, frame_cnt_d;

  // Frame counter steps in the same cycle frame_start rises
  always_comb begin
    if (fs_d) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Frame counter register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign vga_o.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// Self-checking bench: full-size DUT for horizontal timing, reduced-geometry DUT for vertical/frame timing.
module tb_vga_scan_gen;

  typedef struct packed {
    int ha; int hf; int hsy; int hb;
    int va; int vf; int vsy; int vb;
  } cfg_t;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] fc;
    logic        pclk;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        fs;
  } exp_t;

  localparam cfg_t CFG_BIG = '{ha: 640, hf: 16, hsy: 96, hb: 48, va: 480, vf: 10, vsy: 2, vb: 33};
  localparam cfg_t CFG_SML = '{ha: 16, hf: 2, hsy: 3, hb: 3, va: 10, vf: 2, vsy: 2, vb: 3};

  logic Clk = 1'b0;
  logic rst_big;
  logic rst_sml;
  always #10 Clk = ~Clk;

  vga_scan_gen_if big_if ();
  vga_scan_gen_if sml_if ();

  vga_scan_gen u_big (
    .Clk   (Clk),
    .Reset (rst_big),
    .vga_o (big_if)
  );

  vga_scan_gen #(
    .HACT(16), .HFP(2), .HSYNC(3), .HBP(3),
    .VACT(10), .VFP(2), .VSYNC(2), .VBP(3)
  ) u_sml (
    .Clk   (Clk),
    .Reset (rst_sml),
    .vga_o (sml_if)
  );

  int    errors = 0;
  int    checks = 0;
  longint t_big = 0;
  longint t_sml = 0;
  int    big_hs_low = 0;
  int    big_fs_cnt = 0;
  int    sml_vs_low = 0;
  int    sml_fs_cnt = 0;

  // Reference: position is simply (Clk cycles since reset) / 2 laid out on the raster
  function automatic exp_t model(input cfg_t c, input longint t);
    exp_t   e;
    longint ht, vt, p, fl, x, y;
    ht = longint'(c.ha + c.hf + c.hsy + c.hb);
    vt = longint'(c.va + c.vf + c.vsy + c.vb);
    fl = ht * vt;
    p  = t / 2;
    x  = p % ht;
    y  = (p / ht) % vt;
    e.x     = 10'(x);
    e.y     = 10'(y);
    e.fc    = 16'(p / fl);
    e.pclk  = (t % 2) == 1;
    e.hs    = !(x >= c.ha + c.hf && x < c.ha + c.hf + c.hsy);
    e.vs    = !(y >= c.va + c.vf && y < c.va + c.vf + c.vsy);
    e.blank = (x < c.ha) && (y < c.va);
    e.fs    = (t % 2 == 0) && (p > 0) && (p % fl == 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string tag, input cfg_t c, input longint t,
                           input logic pclk, input logic hs, input logic vs, input logic bl,
                           input logic fs, input logic [9:0] x, input logic [9:0] y,
                           input logic [15:0] fc);
    exp_t e;
    e = model(c, t);
    chk({tag, "_DrawX"}, 16'(x), 16'(e.x));
    chk({tag, "_DrawY"}, 16'(y), 16'(e.y));
    chk({tag, "_pixel_clk"}, 16'(pclk), 16'(e.pclk));
    chk({tag, "_hs"}, 16'(hs), 16'(e.hs));
    chk({tag, "_vs"}, 16'(vs), 16'(e.vs));
    chk({tag, "_blank"}, 16'(bl), 16'(e.blank));
    chk({tag, "_frame_start"}, 16'(fs), 16'(e.fs));
`ifdef VGA_FRAME_CNT_EN
    chk({tag, "_frame_cnt"}, fc, e.fc);
`else
    if (fc !== 16'd0) chk({tag, "_frame_cnt_tie"}, fc, 16'd0);
`endif
  endtask

  task automatic cycle();
    logic [15:0] fc_big, fc_sml;
    @(posedge Clk);
    t_big = rst_big ? 64'd0 : t_big + 64'd1;
    t_sml = rst_sml ? 64'd0 : t_sml + 64'd1;
    @(negedge Clk);
`ifdef VGA_FRAME_CNT_EN
    fc_big = big_if.frame_cnt;
    fc_sml = sml_if.frame_cnt;
`else
    fc_big = 16'd0;
    fc_sml = 16'd0;
`endif
    check_dut("big", CFG_BIG, t_big, big_if.pixel_clk, big_if.hs, big_if.vs, big_if.blank,
              big_if.frame_start, big_if.DrawX, big_if.DrawY, fc_big);
    check_dut("sml", CFG_SML, t_sml, sml_if.pixel_clk, sml_if.hs, sml_if.vs, sml_if.blank,
              sml_if.frame_start, sml_if.DrawX, sml_if.DrawY, fc_sml);
    if (big_if.hs === 1'b0) big_hs_low++;
    if (big_if.frame_start === 1'b1) big_fs_cnt++;
    if (sml_if.vs === 1'b0) sml_vs_low++;
    if (sml_if.frame_start === 1'b1) sml_fs_cnt++;
  endtask

  task automatic run_big_to(input longint target);
    int n = 0;
    while (t_big < target && n < 20000) begin
      cycle();
      n++;
    end
    chk("big_reach_target", 16'(t_big == target), 16'd1);
  endtask

  task automatic run_sml_to(input longint target);
    int n = 0;
    while (t_sml < target && n < 20000) begin
      cycle();
      n++;
    end
    chk("sml_reach_target", 16'(t_sml == target), 16'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap, hold;
    rst_big = 1'b1;
    rst_sml = 1'b1;
    repeat (3) cycle();
    chk("rst_DrawX", 16'(big_if.DrawX), 16'd0);
    chk("rst_DrawY", 16'(big_if.DrawY), 16'd0);
    chk("rst_blank", 16'(big_if.blank), 16'd1);
    chk("rst_hs", 16'(big_if.hs), 16'd1);
    chk("rst_vs", 16'(big_if.vs), 16'd1);
    chk("rst_frame_start", 16'(big_if.frame_start), 16'd0);
    rst_big = 1'b0;
    rst_sml = 1'b0;
    repeat (2) cycle();
    chk("x_after_2clk", 16'(big_if.DrawX), 16'd1);

    // Reduced geometry: vertical sync/blank boundaries
    run_sml_to(64'd432);
    chk("sml_blank_y_last_vis", 16'(sml_if.blank), 16'd1);
    run_sml_to(64'd480);
    chk("sml_blank_y_first_hidden", 16'(sml_if.blank), 16'd0);
    run_sml_to(64'd528);
    chk("sml_vs_before", 16'(sml_if.vs), 16'd1);
    run_sml_to(64'd576);
    chk("sml_vs_start", 16'(sml_if.vs), 16'd0);
    run_sml_to(64'd672);
    chk("sml_vs_after", 16'(sml_if.vs), 16'd1);
    chk("sml_vs_low_clks", 16'(sml_vs_low), 16'd96);

    // Full geometry: horizontal sync/blank boundaries on line 0
    run_big_to(64'd1278);
    chk("blank_639_0", 16'(big_if.blank), 16'd1);
    run_big_to(64'd1280);
    chk("blank_640_0", 16'(big_if.blank), 16'd0);
    run_big_to(64'd1310);
    chk("hs_at_655", 16'(big_if.hs), 16'd1);
    run_big_to(64'd1312);
    chk("hs_at_656", 16'(big_if.hs), 16'd0);
    run_big_to(64'd1504);
    chk("hs_at_752", 16'(big_if.hs), 16'd1);
    run_big_to(64'd1599);
    chk("hs_low_clks_line0", 16'(big_hs_low), 16'd192);

    // Two reduced frames: one pulse per frame, none at reset release
    run_sml_to(64'd1632);
    chk("sml_frame_starts", 16'(sml_fs_cnt), 16'd2);
    chk("big_no_frame_start", 16'(big_fs_cnt), 16'd0);
`ifdef VGA_FRAME_CNT_EN
    chk("sml_frame_cnt_2", sml_if.frame_cnt, 16'd2);
`endif

    // Mid-frame reset of the reduced DUT at (10,6)
    run_sml_to(64'd1940);
    chk("sml_pre_reset_x", 16'(sml_if.DrawX), 16'd10);
    chk("sml_pre_reset_y", 16'(sml_if.DrawY), 16'd6);
    rst_sml = 1'b1;
    cycle();
    rst_sml = 1'b0;
    chk("midrst_DrawX", 16'(sml_if.DrawX), 16'd0);
    chk("midrst_DrawY", 16'(sml_if.DrawY), 16'd0);
    chk("midrst_pixel_clk", 16'(sml_if.pixel_clk), 16'd0);
    chk("midrst_frame_start", 16'(sml_if.frame_start), 16'd0);
    repeat (2) cycle();
    chk("midrst_x_resume", 16'(sml_if.DrawX), 16'd1);

    // Randomised reset points on the full-size DUT
    for (int i = 0; i < 4; i++) begin
      gap  = int'($urandom_range(50, 3000));
      hold = int'($urandom_range(1, 3));
      repeat (gap) cycle();
      rst_big = 1'b1;
      repeat (hold) cycle();
      rst_big = 1'b0;
      chk("rand_rst_DrawX", 16'(big_if.DrawX), 16'd0);
      chk("rand_rst_hs", 16'(big_if.hs), 16'd1);
    end
    repeat (700) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
